muldiv_issue_queue: RTL and testbench
=====================================

Name: muldiv_issue_queue

Overview:
- In-order reservation buffer that feeds the combinational multiply/divide execution unit.
- Accepts dispatched M-extension ops and captures missing source operands from the common data bus (CDB).
- Drives operand1/operand2/execute_type into the Mul_Div unit and registers its result for writeback.
- Sits between the dispatch stage and the CDB arbiter.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of two, at least 2.
- TAG_W, 6, width of physical/ROB tags.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous pipeline flush.
- disp_valid  in  1  dispatch op present.
- disp_ready  out  1  queue can accept an op this cycle.
- disp_execute_type  in  5  0=mul, 1=mulh, 2=div, 3=rem.
- disp_rd_tag  in  TAG_W  destination tag.
- disp_op1_rdy  in  1  op1 value valid at dispatch.
- disp_op1_tag  in  TAG_W  producer tag for op1.
- disp_op1  in  32  op1 value.
- disp_op2_rdy  in  1  op2 value valid at dispatch.
- disp_op2_tag  in  TAG_W  producer tag for op2.
- disp_op2  in  32  op2 value.
- cdb_valid  in  1  CDB broadcast present.
- cdb_tag  in  TAG_W  CDB broadcast tag.
- cdb_data  in  32  CDB broadcast value.
- md_operand1  out  32  to Mul_Div operand1.
- md_operand2  out  32  to Mul_Div operand2.
- md_execute_type  out  5  to Mul_Div execute_type.
- md_result  in  32  from Mul_Div result.
- wb_valid  out  1  registered result valid.
- wb_ready  in  1  CDB arbiter accepts result.
- wb_tag  out  TAG_W  result destination tag.
- wb_data  out  32  result value.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All entries invalid; head/tail pointers and count = 0.
  - wb_valid=0, wb_tag=0, wb_data=0.
  - disp_ready goes 1 once reset is released.
- Storage:
  - Circular buffer; tail writes and head issues.
  - Pointers wrap modulo DEPTH.
  - count ranges 0..DEPTH.
- disp_ready = (count != DEPTH). It is registered-state only and has no combinational dependence on issue.
- Dispatch fires on disp_valid & disp_ready. The entry stores type, rd_tag, both operand tags/values and ready bits.
- Dispatch-cycle CDB bypass: if an operand is not ready and cdb_valid & cdb_tag == that operand tag in the same cycle, store cdb_data with ready=1.
- CDB capture: every cycle, each valid entry whose operand is not ready and matches cdb_tag captures cdb_data and sets ready. Both operands may capture from one broadcast.
- Issue:
  - Only the head entry may issue, in order.
  - Condition: head valid, both operands ready, and (!wb_valid | wb_ready).
  - In the issue cycle, md_* are driven combinationally from the head entry.
  - On the edge: wb_data <= md_result, wb_tag <= head rd_tag, wb_valid <= 1, head entry freed.
- No bypass from the CDB into md_* in the same cycle. A head operand captured in cycle N issues no earlier than N+1.
- Idle drive: when not issuing, md_operand1=0, md_operand2=0, md_execute_type=0.
- Latency: dispatch accepted at edge E with both operands ready and writeback empty gives wb_valid=1 after edge E+1 (one cycle in queue).
- Writeback:
  - wb_valid, wb_tag and wb_data hold stable while wb_valid & !wb_ready.
  - wb_valid & wb_ready with no issue clears wb_valid.
  - Back-to-back issue on a wb_ready cycle reloads the register; throughput is 1 op/cycle.
- Simultaneous dispatch and issue: count unchanged. At count==DEPTH, dispatch is refused even if the head issues that cycle.
- Execute_type: passed through unmodified. Codes 4-31 are not rejected; their wb_data is whatever md_result returns.
- Divide by zero and overflow: not checked here; md_result is forwarded as-is.
- Flush:
  - Synchronous and highest priority.
  - Clears all entries, pointers, count and wb_valid.
  - Dispatch in the flush cycle is dropped; no issue occurs.
  - wb_data and wb_tag may keep stale values.
- Reset mid-operation: pending entries and any held result are discarded; no writeback is emitted.

Test Plan:
- Dispatch mul, op1=7, op2=6, both ready, wb_ready=1 -> md_execute_type=0 at E+1; wb_valid=1 with wb_data=42 and wb_tag=disp_rd_tag after E+1; wb_valid=0 next cycle.
- Dispatch div, op1 waiting on tag 5, op2=4; three idle cycles; then cdb_valid, tag 5, data 100 -> no issue before the capture; wb_data=25 two cycles after the broadcast.
- Dispatch DEPTH ops with op1 not ready -> disp_ready=0 when count=4; fifth disp_valid is ignored. Broadcast the tag -> ops issue in dispatch order, one per cycle, and disp_ready returns to 1.
- Hold wb_ready=0 with two ready ops queued -> wb_valid/wb_data stable and no second issue. Raise wb_ready -> second result appears the following cycle; count decrements correctly.
- Dispatch with cdb_valid matching disp_op2_tag in the same cycle (data 3) and op1=9, rem -> wb_data=0. Repeat with op1=10 -> wb_data=1.
- Assert flush with 3 entries and wb_valid=1 -> all cleared next cycle, disp_ready=1, no further wb_valid. Then assert rst_n low mid-stream -> wb_valid=0 immediately, asynchronously.

Source files
------------

// File: rtl/muldiv_issue_queue.sv
// In-order reservation buffer in front of the combinational multiply/divide
// unit. Dispatched M-extension ops wait here until both source operands are
// ready, picking missing values off the CDB. Only the head entry issues.
// Its result is captured in a writeback register that holds until the CDB
// arbiter takes it.
module muldiv_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [4:0]       disp_execute_type,
    input  logic [TAG_W-1:0] disp_rd_tag,
    input  logic             disp_op1_rdy,
    input  logic [TAG_W-1:0] disp_op1_tag,
    input  logic [31:0]      disp_op1,
    input  logic             disp_op2_rdy,
    input  logic [TAG_W-1:0] disp_op2_tag,
    input  logic [31:0]      disp_op2,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic [31:0]      md_operand1,
    output logic [31:0]      md_operand2,
    output logic [4:0]       md_execute_type,
    input  logic [31:0]      md_result,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0]       execute_type;
        logic [TAG_W-1:0] rd_tag;
        logic             op1_rdy;
        logic [TAG_W-1:0] op1_tag;
        logic [31:0]      op1;
        logic             op2_rdy;
        logic [TAG_W-1:0] op2_tag;
        logic [31:0]      op2;
    } entry_t;

    entry_t           q_mem [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    entry_t head_e;
    entry_t disp_e;
    logic   disp_fire;
    logic   issue;

    // Full-ness comes from registered count only, so an issue in the same
    // cycle never opens a slot for dispatch.
    assign disp_ready = (count != CNT_W'(DEPTH));
    assign disp_fire  = disp_valid & disp_ready & ~flush;

    assign head_e = q_mem[head];
    assign issue  = ~flush & q_valid[head] & head_e.op1_rdy & head_e.op2_rdy
                  & (~wb_valid | wb_ready);

    // Build the incoming entry, taking an operand straight off the CDB when
    // its producer broadcasts in the dispatch cycle.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        disp_e              = '0;
        disp_e.execute_type = disp_execute_type;
        disp_e.rd_tag       = disp_rd_tag;
        disp_e.op1_rdy      = disp_op1_rdy;
        disp_e.op1_tag      = disp_op1_tag;
        disp_e.op1          = disp_op1;
        disp_e.op2_rdy      = disp_op2_rdy;
        disp_e.op2_tag      = disp_op2_tag;
        disp_e.op2          = disp_op2;
        if (!disp_op1_rdy && cdb_valid && cdb_tag == disp_op1_tag) begin
            disp_e.op1_rdy = 1'b1;
            disp_e.op1     = cdb_data;
        end
        if (!disp_op2_rdy && cdb_valid && cdb_tag == disp_op2_tag) begin
            disp_e.op2_rdy = 1'b1;
            disp_e.op2     = cdb_data;
        end
    end

    // Entry payload: written on dispatch, operands captured from the CDB.
    // NOTE: the payload array carries no reset; the valid bits alone decide
    // whether an entry means anything, so clearing the data would only add
    // reset fan-out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire && tail == PTR_W'(i)) begin
                q_mem[i] <= disp_e;
            end else if (q_valid[i] && cdb_valid) begin
                if (!q_mem[i].op1_rdy && q_mem[i].op1_tag == cdb_tag) begin
                    q_mem[i].op1_rdy <= 1'b1;
                    q_mem[i].op1     <= cdb_data;
                end
                if (!q_mem[i].op2_rdy && q_mem[i].op2_tag == cdb_tag) begin
                    q_mem[i].op2_rdy <= 1'b1;
                    q_mem[i].op2     <= cdb_data;
                end
            end
        end
    end

    // Queue bookkeeping: valid bits, circular pointers and occupancy.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else if (flush) begin
            q_valid <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            // Head and tail cannot coincide when both fire: that needs an
            // empty queue (nothing to issue) or a full one (no dispatch).
            if (disp_fire) begin
                q_valid[tail] <= 1'b1;
                tail          <= tail + 1'b1;
            end
            if (issue) begin
                q_valid[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            case ({disp_fire, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Drive the execution unit from the head entry only while it issues.
    always_comb begin
        md_operand1     = '0;
        md_operand2     = '0;
        md_execute_type = '0;
        if (issue) begin
            md_operand1     = head_e.op1;
            md_operand2     = head_e.op2;
            md_execute_type = head_e.execute_type;
        end
    end

    // Writeback register: loads on issue, holds under backpressure, and
    // drops when the arbiter takes it without a replacement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_tag   <= '0;
            wb_data  <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (issue) begin
            wb_valid <= 1'b1;
            wb_tag   <= head_e.rd_tag;
            wb_data  <= md_result;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_muldiv_issue_queue.sv
// Directed bench for muldiv_issue_queue with a behavioural multiply/divide
// unit on the md_* side.
module tb_muldiv_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             disp_valid;
    logic             disp_ready;
    logic [4:0]       disp_execute_type;
    logic [TAG_W-1:0] disp_rd_tag;
    logic             disp_op1_rdy;
    logic [TAG_W-1:0] disp_op1_tag;
    logic [31:0]      disp_op1;
    logic             disp_op2_rdy;
    logic [TAG_W-1:0] disp_op2_tag;
    logic [31:0]      disp_op2;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic [31:0]      md_operand1;
    logic [31:0]      md_operand2;
    logic [4:0]       md_execute_type;
    logic [31:0]      md_result;
    logic             wb_valid;
    logic             wb_ready;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .disp_valid        (disp_valid),
        .disp_ready        (disp_ready),
        .disp_execute_type (disp_execute_type),
        .disp_rd_tag       (disp_rd_tag),
        .disp_op1_rdy      (disp_op1_rdy),
        .disp_op1_tag      (disp_op1_tag),
        .disp_op1          (disp_op1),
        .disp_op2_rdy      (disp_op2_rdy),
        .disp_op2_tag      (disp_op2_tag),
        .disp_op2          (disp_op2),
        .cdb_valid         (cdb_valid),
        .cdb_tag           (cdb_tag),
        .cdb_data          (cdb_data),
        .md_operand1       (md_operand1),
        .md_operand2       (md_operand2),
        .md_execute_type   (md_execute_type),
        .md_result         (md_result),
        .wb_valid          (wb_valid),
        .wb_ready          (wb_ready),
        .wb_tag            (wb_tag),
        .wb_data           (wb_data)
    );

    always #5 clk = ~clk;

    // Behavioural Mul_Div unit: mul, mulh, div, rem (RISC-V signed rules).
    logic signed [63:0] prod;
    always_comb begin
        prod      = $signed({{32{md_operand1[31]}}, md_operand1})
                  * $signed({{32{md_operand2[31]}}, md_operand2});
        md_result = '0;
        case (md_execute_type)
            5'd0: md_result = prod[31:0];
            5'd1: md_result = prod[63:32];
            5'd2: md_result = (md_operand2 == 0) ? 32'hffff_ffff
                            : 32'($signed(md_operand1) / $signed(md_operand2));
            5'd3: md_result = (md_operand2 == 0) ? md_operand1
                            : 32'($signed(md_operand1) % $signed(md_operand2));
            default: md_result = 32'hdead_beef;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [4:0] t, input logic [TAG_W-1:0] rd,
                            input logic r1, input logic [TAG_W-1:0] t1, input logic [31:0] v1,
                            input logic r2, input logic [TAG_W-1:0] t2, input logic [31:0] v2);
        disp_valid        = 1'b1;
        disp_execute_type = t;
        disp_rd_tag       = rd;
        disp_op1_rdy      = r1;
        disp_op1_tag      = t1;
        disp_op1          = v1;
        disp_op2_rdy      = r2;
        disp_op2_tag      = t2;
        disp_op2          = v2;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0;
        disp_execute_type = '0; disp_rd_tag = '0;
        disp_op1_rdy = 1'b0; disp_op1_tag = '0; disp_op1 = '0;
        disp_op2_rdy = 1'b0; disp_op2_tag = '0; disp_op2 = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; wb_ready = 1'b1;
        #12 rst_n = 1'b1;
        step();

        // Reset state
        check("rst_disp_ready", 32'(disp_ready), 32'd1);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_tag", 32'(wb_tag), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_md_op1", md_operand1, 32'd0);

        // Simple mul 7*6, one cycle in queue
        dispatch(5'd0, 6'd10, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 32'd6);
        step();
        disp_valid = 1'b0;
        check("mul_md_type", 32'(md_execute_type), 32'd0);
        check("mul_md_op1", md_operand1, 32'd7);
        check("mul_md_op2", md_operand2, 32'd6);
        check("mul_wb_not_yet", 32'(wb_valid), 32'd0);
        step();
        check("mul_wb_valid", 32'(wb_valid), 32'd1);
        check("mul_wb_data", wb_data, 32'd42);
        check("mul_wb_tag", 32'(wb_tag), 32'd10);
        step();
        check("mul_wb_clear", 32'(wb_valid), 32'd0);

        // Div waiting on tag 5, captured from CDB after idle cycles
        dispatch(5'd2, 6'd11, 1'b0, 6'd5, 32'd0, 1'b1, 6'd0, 32'd4);
        step();
        disp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("div_wait_md_op2", md_operand2, 32'd0);
            step();
            check("div_wait_wb", 32'(wb_valid), 32'd0);
        end
        cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_data = 32'd100;
        #1;
        check("div_no_cdb_bypass", md_operand1, 32'd0);
        step();
        cdb_valid = 1'b0;
        check("div_md_op1", md_operand1, 32'd100);
        check("div_md_type", 32'(md_execute_type), 32'd2);
        check("div_wb_early", 32'(wb_valid), 32'd0);
        step();
        check("div_wb_valid", 32'(wb_valid), 32'd1);
        check("div_wb_data", wb_data, 32'd25);
        check("div_wb_tag", 32'(wb_tag), 32'd11);
        step();

        // Fill queue, refuse fifth, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_ready", 32'(disp_ready), 32'd1);
            dispatch(5'd0, 6'(20 + i), 1'b0, 6'd7, 32'd0, 1'b1, 6'd0, 32'(i + 1));
            step();
        end
        check("full_not_ready", 32'(disp_ready), 32'd0);
        dispatch(5'd0, 6'd24, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd5);
        step();
        disp_valid = 1'b0;
        check("full_still_not_ready", 32'(disp_ready), 32'd0);
        check("full_no_issue", md_operand2, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'd3;
        step();
        cdb_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            check("drain_wb_valid", 32'(wb_valid), 32'd1);
            check("drain_wb_data", wb_data, 32'(3 * (i + 1)));
            check("drain_wb_tag", 32'(wb_tag), 32'(20 + i));
            check("drain_ready", 32'(disp_ready), 32'd1);
        end
        step();
        check("drain_no_fifth", 32'(wb_valid), 32'd0);

        // Backpressure with two ready ops
        wb_ready = 1'b0;
        dispatch(5'd0, 6'd30, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 32'd3);
        step();
        dispatch(5'd0, 6'd31, 1'b1, 6'd0, 32'd4, 1'b1, 6'd0, 32'd5);
        step();
        disp_valid = 1'b0;
        check("bp_first_data", wb_data, 32'd6);
        for (int i = 0; i < 2; i++) begin
            step();
            check("bp_hold_valid", 32'(wb_valid), 32'd1);
            check("bp_hold_data", wb_data, 32'd6);
            check("bp_hold_tag", 32'(wb_tag), 32'd30);
            check("bp_no_issue", md_operand1, 32'd0);
        end
        wb_ready = 1'b1;
        #1;
        check("bp_release_issue", md_operand1, 32'd4);
        step();
        check("bp_second_valid", 32'(wb_valid), 32'd1);
        check("bp_second_data", wb_data, 32'd20);
        check("bp_second_tag", 32'(wb_tag), 32'd31);
        step();
        check("bp_empty", 32'(wb_valid), 32'd0);
        check("bp_empty_md", md_operand1, 32'd0);

        // Dispatch-cycle CDB bypass on op2, rem
        dispatch(5'd3, 6'd40, 1'b1, 6'd0, 32'd9, 1'b0, 6'd12, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'd3;
        step();
        disp_valid = 1'b0; cdb_valid = 1'b0;
        step();
        check("rem9_valid", 32'(wb_valid), 32'd1);
        check("rem9_data", wb_data, 32'd0);
        step();
        dispatch(5'd3, 6'd41, 1'b1, 6'd0, 32'd10, 1'b0, 6'd12, 32'd0);
        cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'd3;
        step();
        disp_valid = 1'b0; cdb_valid = 1'b0;
        step();
        check("rem10_valid", 32'(wb_valid), 32'd1);
        check("rem10_data", wb_data, 32'd1);
        check("rem10_tag", 32'(wb_tag), 32'd41);
        step();

        // Flush with three queued entries and a held result
        wb_ready = 1'b0;
        dispatch(5'd0, 6'd50, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
        step();
        for (int i = 0; i < 3; i++) begin
            dispatch(5'd0, 6'(51 + i), 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 32'd2);
            step();
        end
        check("pre_flush_valid", 32'(wb_valid), 32'd1);
        check("pre_flush_ready", 32'(disp_ready), 32'd1);
        dispatch(5'd0, 6'd59, 1'b1, 6'd0, 32'd8, 1'b1, 6'd0, 32'd8);
        flush = 1'b1; wb_ready = 1'b1;
        step();
        flush = 1'b0; disp_valid = 1'b0;
        check("flush_wb_valid", 32'(wb_valid), 32'd0);
        check("flush_disp_ready", 32'(disp_ready), 32'd1);
        check("flush_empty_md", md_operand1, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_flush_no_wb", 32'(wb_valid), 32'd0);
        end

        // Asynchronous reset while a result is held
        wb_ready = 1'b0;
        dispatch(5'd0, 6'd60, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd5);
        step();
        disp_valid = 1'b0;
        step();
        check("pre_rst_valid", 32'(wb_valid), 32'd1);
        check("pre_rst_data", wb_data, 32'd25);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(wb_valid), 32'd0);
        check("async_rst_data", wb_data, 32'd0);
        check("async_rst_tag", 32'(wb_tag), 32'd0);
        #2 rst_n = 1'b1;
        wb_ready = 1'b1;
        step();
        check("post_rst_valid", 32'(wb_valid), 32'd0);
        check("post_rst_ready", 32'(disp_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
